// File: rtl/loanio_uart_tx_multi.sv
`default_nettype none
// loanio_uart_tx_multi: independent per-channel byte FIFO + UART frame engine, routed onto HPS loan-I/O pins.
// Rev 1.0
module loanio_uart_tx_multi #(
  parameter int                    CHANNELS   = 3,
  parameter int                    CLK_HZ     = 50000000,
  parameter int                    BAUD       = 115200,
  parameter int                    DATA_BITS  = 8,
  parameter int                    PARITY     = 0,
  parameter int                    STOP_BITS  = 1,
  parameter int                    FIFO_DEPTH = 16,
  parameter logic [7*CHANNELS-1:0] PIN_MAP    = {7'd53, 7'd50, 7'd49}
) (
  input  logic                                         clk_clk,
  input  logic                                         reset_reset,
  input  logic [CHANNELS-1:0]                          wr_valid,
  input  logic [8*CHANNELS-1:0]                        wr_data,
  output logic [CHANNELS-1:0]                          wr_ready,
  output logic [CHANNELS*($clog2(FIFO_DEPTH)+1)-1:0]   fifo_level,
  output logic [CHANNELS-1:0]                          busy,
  output logic [66:0]                                  loan_io_out,
  output logic [66:0]                                  loan_io_oe
);

  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int BW  = 3;

  localparam logic [CW-1:0] CNT_TOP  = CW'(DIV - 1);
  localparam logic [BW-1:0] DATA_TOP = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_TOP = BW'(STOP_BITS - 1);

  function automatic bit pin_map_ok();
    for (int i = 0; i < CHANNELS; i++) begin
      if (PIN_MAP[7*i +: 7] > 7'd66) return 1'b0;
      for (int j = 0; j < i; j++)
        if (PIN_MAP[7*i +: 7] == PIN_MAP[7*j +: 7]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [66:0] oe_mask();
    logic [66:0] m;
    m = '0;
    for (int i = 0; i < CHANNELS; i++) m[PIN_MAP[7*i +: 7]] = 1'b1;
    return m;
  endfunction

  localparam bit          PIN_OK  = pin_map_ok();
  localparam logic [66:0] OE_MASK = oe_mask();

  generate
    if (DIV < 2) begin : g_bad_div
      $error("loanio_uart_tx_multi: DIV must be at least 2");
    end
    if (CHANNELS < 1 || CHANNELS > 8 || DATA_BITS < 5 || DATA_BITS > 8 ||
        PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_fmt
      $error("loanio_uart_tx_multi: illegal channel count or frame format");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("loanio_uart_tx_multi: FIFO_DEPTH must be a power of 2, at least 2");
    end
    if (!PIN_OK) begin : g_bad_pins
      $error("loanio_uart_tx_multi: PIN_MAP indices must be distinct and <= 66");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  logic [CHANNELS-1:0] line_all;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic                 ready_q, ready_d;
    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 line_q, line_d;
    logic                 push, pop;
    logic [DATA_BITS-1:0] head;

    if (DATA_BITS < 8) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^wr_data[8*c+DATA_BITS +: 8-DATA_BITS];
    end

    always_comb begin
      push    = wr_valid[c] & ready_q;
      head    = mem_q[rptr_q];
      pop     = 1'b0;
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;

      case (state_q)
        ST_IDLE: if (level_q != '0) pop = 1'b1;
        ST_START: begin
          if (cnt_q == '0) begin
            state_d = ST_DATA;
            cnt_d   = CNT_TOP;
            bit_d   = DATA_TOP;
          end else cnt_d = cnt_q - 1'b1;
        end
        ST_DATA: begin
          if (cnt_q == '0) begin
            cnt_d = CNT_TOP;
            if (bit_q == '0) begin
              state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
              bit_d   = STOP_TOP;
            end else begin
              shift_d = shift_q >> 1;
              bit_d   = bit_q - 1'b1;
            end
          end else cnt_d = cnt_q - 1'b1;
        end
        ST_PARITY: begin
          if (cnt_q == '0) begin
            state_d = ST_STOP;
            cnt_d   = CNT_TOP;
            bit_d   = STOP_TOP;
          end else cnt_d = cnt_q - 1'b1;
        end
        ST_STOP: begin
          // The last stop clock chains straight into the next start bit when data is waiting.
          if (cnt_q == '0) begin
            if (bit_q != '0) begin
              bit_d = bit_q - 1'b1;
              cnt_d = CNT_TOP;
            end else if (level_q != '0) pop = 1'b1;
            else state_d = ST_IDLE;
          end else cnt_d = cnt_q - 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase

      if (pop) begin
        state_d = ST_START;
        cnt_d   = CNT_TOP;
        shift_d = head;
        par_d   = (PARITY == 1) ? ~^head : ^head;
      end

      case (state_q)
        ST_START:  line_d = 1'b0;
        ST_DATA:   line_d = shift_q[0];
        ST_PARITY: line_d = par_q;
        default:   line_d = 1'b1;
      endcase

      wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
      rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
      level_d = level_q + LW'(push) - LW'(pop);
      // Ready ignores this cycle's pop, so freed space shows up one cycle later.
      ready_d = (level_q + LW'(push)) < LW'(FIFO_DEPTH);
    end

    always_ff @(posedge clk_clk) begin
      if (push) mem_q[wptr_q] <= wr_data[8*c +: DATA_BITS];
    end

    always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        bit_q   <= '0;
        shift_q <= '0;
        par_q   <= 1'b0;
        line_q  <= 1'b1;
        wptr_q  <= '0;
        rptr_q  <= '0;
        level_q <= '0;
        ready_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        bit_q   <= bit_d;
        shift_q <= shift_d;
        par_q   <= par_d;
        line_q  <= line_d;
        wptr_q  <= wptr_d;
        rptr_q  <= rptr_d;
        level_q <= level_d;
        ready_q <= ready_d;
      end
    end

    assign line_all[c]               = line_q;
    assign wr_ready[c]               = ready_q;
    assign fifo_level[LW*c +: LW]    = level_q;
    assign busy[c]                   = (state_q != ST_IDLE) || (level_q != '0);
  end

  always_comb begin
    loan_io_out = '0;
    for (int i = 0; i < CHANNELS; i++) loan_io_out[PIN_MAP[7*i +: 7]] = line_all[i];
  end

  assign loan_io_oe = OE_MASK;

endmodule
`default_nettype wire

// File: tb/tb_loanio_uart_tx_multi.sv
`default_nettype none
// tb_loanio_uart_tx_multi: table vectors and directed corners on two configurations, plus
// randomized traffic on the 8N1 instance compared against a frame-timing model.
module tb_loanio_uart_tx_multi;
  localparam int CLK_HZ = 400;
  localparam int BAUD   = 100;
  localparam int DIV    = 4;
  localparam int D      = 16;
  localparam int FL0    = DIV * 10;
  localparam int PIN0 [3] = '{49, 50, 53};
  localparam logic [66:0] OE0 = (67'd1 << 49) | (67'd1 << 50) | (67'd1 << 53);
  localparam logic [66:0] OE1 = 67'd1 << 66;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]  v0 = '0;
  logic [23:0] d0 = '0;
  logic [2:0]  rdy0, busy0;
  logic [14:0] lvl0;
  logic [66:0] out0, oe0;
  logic        v1 = 1'b0;
  logic [7:0]  d1 = '0;
  logic        rdy1, busy1;
  logic [4:0]  lvl1;
  logic [66:0] out1, oe1;

  loanio_uart_tx_multi #(
    .CHANNELS(3), .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
    .STOP_BITS(1), .FIFO_DEPTH(D), .PIN_MAP({7'd53, 7'd50, 7'd49})
  ) dut0 (
    .clk_clk(clk), .reset_reset(rst), .wr_valid(v0), .wr_data(d0), .wr_ready(rdy0),
    .fifo_level(lvl0), .busy(busy0), .loan_io_out(out0), .loan_io_oe(oe0)
  );

  loanio_uart_tx_multi #(
    .CHANNELS(1), .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(2),
    .STOP_BITS(2), .FIFO_DEPTH(D), .PIN_MAP(7'd66)
  ) dut1 (
    .clk_clk(clk), .reset_reset(rst), .wr_valid(v1), .wr_data(d1), .wr_ready(rdy1),
    .fifo_level(lvl1), .busy(busy1), .loan_io_out(out1), .loan_io_oe(oe1)
  );

  int checks = 0;
  int errors = 0;
  int t = 0;

  task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, t);
    end
  endtask

  // Frame-level model of dut0: each accepted byte gets a start time
  // max(accept+2, previous start + frame length); everything else follows from those times.
  int          q_start [3][$];
  logic [7:0]  q_data  [3][$];
  int          last_start [3];
  logic [2:0]  m_ready = '0;

  function automatic logic frame_bit(input logic [7:0] data, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return data[slot-1];
    return 1'b1;
  endfunction

  task automatic check_outputs();
    logic [66:0] eo;
    logic [14:0] el;
    logic [2:0]  eb;
    eo = '0;
    el = '0;
    eb = '0;
    for (int c = 0; c < 3; c++) begin
      logic pin;
      int   lv;
      pin = 1'b1;
      lv  = 0;
      if (q_start[c].size() > 0 && q_start[c][0] <= t)
        pin = frame_bit(q_data[c][0], (t - q_start[c][0]) / DIV);
      for (int k = 0; k < q_start[c].size(); k++) begin
        if (q_start[c][k] - 1 > t) lv++;
        if (q_start[c][k] + FL0 - 2 >= t) eb[c] = 1'b1;
      end
      eo[PIN0[c]]  = pin;
      el[5*c +: 5] = lv[4:0];
    end
    check("model_out", out0, eo);
    check("model_oe", oe0, OE0);
    check("model_level", 67'(lvl0), 67'(el));
    check("model_busy", 67'(busy0), 67'(eb));
    check("model_ready", 67'(rdy0), 67'(m_ready));
  endtask

  initial begin
    forever begin
      @(posedge clk);
      t++;
      for (int c = 0; c < 3; c++) begin
        int s, n;
        if (rst) begin
          q_start[c].delete();
          q_data[c].delete();
          last_start[c] = -100000;
          m_ready[c] = 1'b0;
        end else begin
          if (v0[c] && m_ready[c]) begin
            s = (t + 2 > last_start[c] + FL0) ? t + 2 : last_start[c] + FL0;
            q_start[c].push_back(s);
            q_data[c].push_back(d0[8*c +: 8]);
            last_start[c] = s;
          end
          while (q_start[c].size() > 0 && q_start[c][0] + FL0 <= t) begin
            void'(q_start[c].pop_front());
            void'(q_data[c].pop_front());
          end
          n = 0;
          for (int k = 0; k < q_start[c].size(); k++)
            if (q_start[c][k] - 1 >= t) n++;
          m_ready[c] = (n < D);
        end
      end
      @(negedge clk);
      check_outputs();
    end
  end

  function automatic logic get_pin(input int inst, input int ch);
    return (inst == 0) ? out0[PIN0[ch]] : out1[66];
  endfunction
  function automatic int get_level(input int inst, input int ch);
    return (inst == 0) ? int'(lvl0[5*ch +: 5]) : int'(lvl1);
  endfunction
  function automatic logic get_busy(input int inst, input int ch);
    return (inst == 0) ? busy0[ch] : busy1;
  endfunction
  task automatic drive(input int inst, input int ch, input logic [7:0] data, input logic val);
    if (inst == 0) begin
      v0[ch] = val;
      d0[8*ch +: 8] = data;
    end else begin
      v1 = val;
      d1 = data;
    end
  endtask

  typedef struct {
    int         inst;
    int         ch;
    logic [7:0] data;
    int         nslots;
    logic [11:0] frame;
  } vec_t;
  vec_t tbl [8];

  logic [9:0] fa, fc;
  int acc, first_low;

  initial begin
    tbl[0] = '{0, 0, 8'h55, 10, 12'h2AA};
    tbl[1] = '{0, 1, 8'hA5, 10, 12'h34A};
    tbl[2] = '{0, 2, 8'h00, 10, 12'h200};
    tbl[3] = '{0, 0, 8'hFF, 10, 12'h3FE};
    tbl[4] = '{1, 0, 8'h07, 11, 12'h70E};
    tbl[5] = '{1, 0, 8'hFF, 11, 12'h7FE};
    tbl[6] = '{1, 0, 8'h80, 11, 12'h600};
    tbl[7] = '{1, 0, 8'h01, 11, 12'h702};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready1", 67'(rdy1), 67'(1));
    check("rst_level1", 67'(lvl1), 67'(0));
    check("rst_busy1", 67'(busy1), 67'(0));
    check("rst_out1", out1, OE1);
    check("rst_oe1", oe1, OE1);
    check("rst_out0", out0, OE0);

    // Single frames from the vector table, sampled mid-bit.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(tbl[i].inst, tbl[i].ch, tbl[i].data, 1'b1);
      @(negedge clk);
      drive(tbl[i].inst, tbl[i].ch, 8'h00, 1'b0);
      check("tbl_level_after_T", 67'(get_level(tbl[i].inst, tbl[i].ch)), 67'(1));
      @(negedge clk);
      check("tbl_idle_before_start", 67'(get_pin(tbl[i].inst, tbl[i].ch)), 67'(1));
      check("tbl_level_after_pop", 67'(get_level(tbl[i].inst, tbl[i].ch)), 67'(0));
      repeat (2) @(negedge clk);
      for (int s = 0; s < tbl[i].nslots; s++) begin
        check($sformatf("tbl%0d_slot%0d", i, s), 67'(get_pin(tbl[i].inst, tbl[i].ch)), 67'(tbl[i].frame[s]));
        if (s < tbl[i].nslots - 1) repeat (DIV) @(negedge clk);
      end
      @(negedge clk);
      check("tbl_busy_last_stop", 67'(get_busy(tbl[i].inst, tbl[i].ch)), 67'(1));
      @(negedge clk);
      check("tbl_busy_done", 67'(get_busy(tbl[i].inst, tbl[i].ch)), 67'(0));
      check("tbl_line_high", 67'(get_pin(tbl[i].inst, tbl[i].ch)), 67'(1));
      repeat (3) @(negedge clk);
    end

    // Channel independence: ch0 and ch2 start in the same cycle.
    fa = 10'h34A;
    fc = 10'h278;
    @(negedge clk);
    v0 = 3'b101;
    d0 = {8'h3C, 8'h00, 8'hA5};
    @(negedge clk);
    v0 = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 10; s++) begin
      check("indep_ch0", 67'(out0[49]), 67'(fa[s]));
      check("indep_ch2", 67'(out0[53]), 67'(fc[s]));
      check("indep_ch1", 67'(out0[50]), 67'(1));
      check("indep_oe", oe0, OE0);
      repeat (DIV) @(negedge clk);
    end
    repeat (10) @(negedge clk);

    // FIFO full on ch1.
    acc = 0;
    first_low = -1;
    for (int k = 0; k < 20; k++) begin
      v0[1] = 1'b1;
      d0[15:8] = 8'($urandom);
      if (rdy0[1]) acc++;
      else if (first_low < 0) first_low = k;
      @(negedge clk);
    end
    v0[1] = 1'b0;
    check("full_accepted", 67'(acc), 67'(17));
    check("full_ready_fall", 67'(first_low), 67'(17));
    check("full_ready_low", 67'(rdy0[1]), 67'(0));
    check("full_level", 67'(lvl0[9:5]), 67'(16));
    repeat (17 * FL0 + 20) @(negedge clk);
    check("full_drained", 67'(busy0), 67'(0));

    // Push and pop on the same edge (last stop clock) with one entry queued.
    @(negedge clk);
    v0[0] = 1'b1;
    d0[7:0] = 8'h11;
    @(negedge clk);
    d0[7:0] = 8'h22;
    @(negedge clk);
    v0[0] = 1'b0;
    check("pp_level_one", 67'(lvl0[4:0]), 67'(1));
    repeat (FL0 - 1) @(negedge clk);
    v0[0] = 1'b1;
    d0[7:0] = 8'h33;
    @(negedge clk);
    v0[0] = 1'b0;
    check("pp_level_kept", 67'(lvl0[4:0]), 67'(1));
    check("pp_stop_high", 67'(out0[49]), 67'(1));
    @(negedge clk);
    check("pp_next_start", 67'(out0[49]), 67'(0));
    repeat (2 * FL0 + 10) @(negedge clk);

    // Reset during data bit 3 with four bytes still queued on ch2.
    for (int k = 0; k < 5; k++) begin
      v0[2] = 1'b1;
      d0[23:16] = 8'($urandom);
      @(negedge clk);
    end
    v0[2] = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_line", 67'(out0[53]), 67'(1));
    check("rstmid_level", 67'(lvl0[14:10]), 67'(0));
    check("rstmid_busy", 67'(busy0), 67'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check("post_reset_out", out0, OE0);
    check("post_reset_busy", 67'(busy0), 67'(0));

    // Randomized traffic, alternating sparse and bursty phases.
    for (int k = 0; k < 4000; k++) begin
      int thr;
      @(negedge clk);
      thr = ((k / 500) % 2 == 1) ? 40 : 2;
      for (int c = 0; c < 3; c++) v0[c] = ($urandom_range(0, 99) < thr);
      d0 = 24'($urandom);
    end
    @(negedge clk);
    v0 = '0;
    repeat (18 * FL0) @(negedge clk);
    check("random_drained", 67'(busy0), 67'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/loanio_uart_tx_multi.md
# loanio_uart_tx_multi

Parametrised multi-channel UART transmitter that drives HPS loan-I/O pins from FPGA fabric. Each channel has its own byte FIFO, frame engine and configurable frame format; its serial output is routed onto a chosen bit of the 67-bit `hps_h2f_loan_io_out`/`_oe` bus. It sits between fabric logic (or an Avalon bridge) and the `soc_system` loan-I/O conduit.

## Interface

**Parameters** (name, default, meaning)
- `CHANNELS`, 3: number of independent TX channels, 1..8.
- `CLK_HZ`, 50000000: `clk_clk` frequency.
- `BAUD`, 115200: line rate. `DIV = (CLK_HZ + BAUD/2) / BAUD` clocks per bit. Elaboration error if `DIV < 2`.
- `DATA_BITS`, 8: data bits per frame, 5..8. Sent LSB first.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 16: entries per channel. Must be a power of 2, at least 2.
- `PIN_MAP`, {7'd53, 7'd50, 7'd49}: packed `CHANNELS` x 7-bit loan-I/O indices. Channel `c` uses bits `[7c+6:7c]`. Indices must be distinct and ≤ 66.

**Ports** (name, direction, width, meaning)
- `clk_clk`, in, 1: sole clock.
- `reset_reset`, in, 1: synchronous reset, active-high.
- `wr_valid`, in, `CHANNELS`: per-channel byte write strobe.
- `wr_data`, in, `8*CHANNELS`: channel `c` at `[8c+7:8c]`. Bits above `DATA_BITS` are ignored.
- `wr_ready`, out, `CHANNELS`: channel FIFO not full.
- `fifo_level`, out, `CHANNELS*($clog2(FIFO_DEPTH)+1)`: per-channel FIFO occupancy.
- `busy`, out, `CHANNELS`: frame in progress or FIFO not empty.
- `loan_io_out`, out, 67: connects to `hps_h2f_loan_io_out`.
- `loan_io_oe`, out, 67: connects to `hps_h2f_loan_io_oe`.

## Operation

- **Write:** a byte is accepted on a rising edge with `wr_valid[c] & wr_ready[c]`. Writes while not ready are dropped silently.
- **`wr_ready`:** `wr_ready[c] = (level < FIFO_DEPTH)`, registered from the current level. A pop in the same cycle does not raise `wr_ready` until the next cycle. A simultaneous push and pop leaves the level unchanged.
- **Frame FSM per channel:** IDLE → START → DATA → (PARITY if `PARITY≠0`) → STOP → IDLE or START.
  - **IDLE:** line = 1. If the FIFO is non-empty, pop the head into the shift register, load the bit counter and enter START.
  - **START:** line = 0 for `DIV` clocks.
  - **DATA:** shift out `DATA_BITS` bits, `DIV` clocks each, LSB first.
  - **PARITY:** one bit over the `DATA_BITS` data bits. Odd: line = ~^data. Even: line = ^data.
  - **STOP:** line = 1 for `STOP_BITS*DIV` clocks. On the last STOP clock, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- **Frame length:** `DIV*(1 + DATA_BITS + (PARITY≠0) + STOP_BITS)` clocks.
- **Baud counter:** counts `DIV-1` down to 0 per bit. Bit/state advance happens on the 0 cycle. Counter width is `$clog2(DIV)`.
- **Pin routing:**
  - `loan_io_out[PIN_MAP[c]]` = line of channel `c`, registered (no combinational path from the FSM).
  - `loan_io_oe[PIN_MAP[c]] = 1` permanently, including during reset.
  - All unmapped bits: out = 0, oe = 0.
- **`busy[c]`:** 1 when state ≠ IDLE or level ≠ 0.
- Channels are fully independent; there is no shared arbitration.

## Timing

- **Reset values:** FIFOs empty, `fifo_level = 0`, `wr_ready = all 1` (visible the cycle after reset deasserts), `busy = 0`, all FSMs IDLE, mapped `loan_io_out` bits = 1, mapped `loan_io_oe` = 1, unmapped out/oe = 0.
- **Reset mid-frame:** the frame is aborted and the line is driven high on the first clock edge with `reset_reset = 1`. The FIFO contents are discarded.
- **Latency:** with the channel idle and empty, a byte accepted at edge T drives the start bit (line = 0) on the pin from edge T+2. `fifo_level` shows 1 after T, then 0 after T+1.
- **Back-to-back:** consecutive frames are contiguous. The start bit of frame n+1 begins exactly `frame_length` clocks after the start of frame n.
- **Throughput:** one write per channel per cycle while `wr_ready` is high. Filling an empty FIFO of depth D takes D+1 writes before `wr_ready` falls, because the head is popped after one cycle.

## Test plan

- **Basic frame:** `DIV=4`, 8N1, write 0x55 on ch0. Line at `PIN_MAP[0]` goes 0 from T+2 for 4 clocks, then 1,0,1,0,1,0,1,0 at 4 clocks each, then 1 for 4 clocks. Total 40 clocks. `busy[0]` falls after the stop bit.
- **Parity and stop bits:** `PARITY=2`, `STOP_BITS=2`, `DATA_BITS=7`, write 0x07. The parity bit is 1, the stop level lasts 8 clocks, and the frame is 44 clocks at `DIV=4`.
- **FIFO full:** hold `wr_valid[1]` for 20 cycles with `FIFO_DEPTH=16`. Exactly 17 bytes are accepted, `wr_ready[1]` is 0 from the cycle after the 17th write, and 17 frames are emitted back-to-back with no gap.
- **Channel independence:** write 0xA5 to ch0 and 0x3C to ch2 in the same cycle. Both waveforms are correct and simultaneous, ch1 stays high, and unmapped `loan_io_oe` bits are 0.
- **Reset mid-frame:** assert `reset_reset` during DATA bit 3 of a frame with 4 more bytes queued. Line = 1 on the next edge, `fifo_level = 0`, `busy = 0`, and no further frames are emitted after reset is released.
- **Simultaneous push/pop:** on the last STOP clock with 1 entry queued, write a new byte. `fifo_level` stays 1 and the next START follows immediately.
